fpu_share_ctrl: RTL and testbench

- Sequencer and round-robin arbiter that shares one floating_alu instance between NUM_REQ requesters, such as per-thread lanes of the compute core.
- Accepts one operation at a time over a valid/ready handshake and drives the ALU's enable, operands and instruction.
- Waits out the ALU latency, captures the result and returns it to the owning requester over a valid/ready response handshake.

---
 rtl/fpu_share_ctrl_pkg.sv | 16 +
 rtl/fpu_share_ctrl_rr_arbiter.sv | 30 +++
 rtl/fpu_share_ctrl.sv | 102 ++++++++++
 tb/tb_fpu_share_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_share_ctrl_pkg.sv
// rtl/fpu_share_ctrl_pkg.sv - shared types and defaults for the FPU sharing controller
package fpu_share_ctrl_pkg;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_FADD, ALU_FSUB, ALU_FMUL, ALU_FDIV, ALU_FLT, ALU_FLE,
    ALU_FEQ, ALU_BEQZ, ALU_JAL, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL
  } alu_instruction_t;

  localparam int ALU_INSTR_W = $bits(alu_instruction_t);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} fpu_share_state_t;

  localparam int FPU_ALU_LATENCY = 1;
  localparam int NUM_FPU_REQ     = 4;

endpackage

// File: rtl/fpu_share_ctrl_rr_arbiter.sv
// rtl/fpu_share_ctrl_rr_arbiter.sv - combinational round-robin arbiter, search starts after rr_ptr
module fpu_share_ctrl_rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic             found;
  logic [IDX_W-1:0] idx;

  always_comb begin
    found     = 1'b0;
    grant     = '0;
    grant_idx = '0;
    idx       = '0;
    for (int k = 1; k <= N; k++) begin
      idx = IDX_W'((int'(rr_ptr) + k) % N);
      if (!found && req[idx]) begin
        found     = 1'b1;
        grant_idx = idx;
      end
    end
    if (found) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/fpu_share_ctrl.sv
// rtl/fpu_share_ctrl.sv - shares one floating ALU between NUM_REQ requesters, one op in flight
module fpu_share_ctrl
  import fpu_share_ctrl_pkg::*;
#(
  parameter int NUM_REQ     = NUM_FPU_REQ,
  parameter int ALU_LATENCY = FPU_ALU_LATENCY,
  parameter int CNT_W       = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*32-1:0]          req_op1,
  input  logic [NUM_REQ*32-1:0]          req_op2,
  input  logic [NUM_REQ*ALU_INSTR_W-1:0] req_instr,
  output logic [NUM_REQ-1:0]             resp_valid,
  input  logic [NUM_REQ-1:0]             resp_ready,
  output logic [31:0]                    resp_result,
  output logic                           alu_enable,
  output logic [31:0]                    alu_op1,
  output logic [31:0]                    alu_op2,
  output alu_instruction_t               alu_instruction,
  input  logic [31:0]                    alu_result,
  output logic                           busy
);

  localparam int IDX_W = $clog2(NUM_REQ);

  fpu_share_state_t state, state_next;
  logic [IDX_W-1:0] owner, rr_ptr, grant_idx;
  logic [NUM_REQ-1:0] grant;
  logic [CNT_W-1:0] cnt;
  logic grant_any;

  fpu_share_ctrl_rr_arbiter #(.N(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .req       (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign grant_any = |grant;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_any) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (cnt == '0) state_next = RESP;
      RESP:    if (resp_ready[owner]) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // req_ready is gated by reset so a held req_valid cannot look accepted while in reset
  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    alu_enable = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE:    req_ready = reset ? grant : '0;
      ISSUE:   alu_enable = 1'b1;
      RESP:    resp_valid[owner] = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner           <= '0;
      rr_ptr          <= IDX_W'(NUM_REQ - 1);
      cnt             <= '0;
      alu_op1         <= '0;
      alu_op2         <= '0;
      alu_instruction <= alu_instruction_t'('0);
      resp_result     <= '0;
    end else begin
      case (state)
        IDLE: if (grant_any) begin
          alu_op1         <= req_op1[32*int'(grant_idx) +: 32];
          alu_op2         <= req_op2[32*int'(grant_idx) +: 32];
          alu_instruction <= alu_instruction_t'(req_instr[ALU_INSTR_W*int'(grant_idx) +: ALU_INSTR_W]);
          owner           <= grant_idx;
        end
        ISSUE: cnt <= CNT_W'(ALU_LATENCY - 1);
        WAIT: begin
          if (cnt == '0) resp_result <= alu_result;
          else           cnt <= cnt - 1'b1;
        end
        RESP: if (resp_ready[owner]) rr_ptr <= owner;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_share_ctrl.sv
// tb/tb_fpu_share_ctrl.sv - self-checking bench for fpu_share_ctrl with a behavioural ALU and arbitration model
module tb_fpu_share_ctrl;
  import fpu_share_ctrl_pkg::*;

  localparam int N = 4;

  logic clk, reset;
  logic [N-1:0] req_valid, req_ready, resp_valid, resp_ready;
  logic [N*32-1:0] req_op1, req_op2;
  logic [N*ALU_INSTR_W-1:0] req_instr;
  logic [31:0] resp_result, alu_op1, alu_op2, alu_result;
  logic alu_enable, busy;
  alu_instruction_t alu_instruction;

  logic [N-1:0] req_valid3, req_ready3, resp_valid3;
  logic [31:0] resp_result3, alu_op1_3, alu_op2_3, alu_result3;
  logic alu_enable3, busy3;
  alu_instruction_t alu_instr3;

  logic [31:0] pipe1;
  logic [31:0] pipe3 [3];
  logic [31:0] op1s [N];
  logic [31:0] op2s [N];
  alu_instruction_t inss [N];

  int checks = 0;
  int passed = 0;
  int cyc = 0;

  fpu_share_ctrl #(.NUM_REQ(N), .ALU_LATENCY(1), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op1(req_op1), .req_op2(req_op2), .req_instr(req_instr),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
    .alu_enable(alu_enable), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_instruction(alu_instruction), .alu_result(alu_result), .busy(busy)
  );

  fpu_share_ctrl #(.NUM_REQ(N), .ALU_LATENCY(3), .CNT_W(4)) dut3 (
    .clk(clk), .reset(reset), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_op1(req_op1), .req_op2(req_op2), .req_instr(req_instr),
    .resp_valid(resp_valid3), .resp_ready(resp_ready), .resp_result(resp_result3),
    .alu_enable(alu_enable3), .alu_op1(alu_op1_3), .alu_op2(alu_op2_3),
    .alu_instruction(alu_instr3), .alu_result(alu_result3), .busy(busy3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic real f2r(input logic [31:0] b);
    real m;
    int e;
    if (b[30:0] == 31'h0) return 0.0;
    m = 1.0 + real'(b[22:0]) / 8388608.0;
    e = int'(b[30:23]) - 127;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return b[31] ? -m : m;
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic s;
    int e;
    real a;
    if (r == 0.0) return 32'h0;
    s = (r < 0.0);
    a = s ? -r : r;
    e = 127;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0) begin a = a * 2.0; e--; end
    return {s, 8'(e), 23'($rtoi((a - 1.0) * 8388608.0))};
  endfunction

  // Behavioural floating ALU: real arithmetic for FADD/FMUL, an arbitrary mix for the rest
  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b, input alu_instruction_t ins);
    case (ins)
      ALU_FADD: return r2f(f2r(a) + f2r(b));
      ALU_FMUL: return r2f(f2r(a) * f2r(b));
      default:  return (a ^ {b[15:0], b[31:16]}) + 32'(ins);
    endcase
  endfunction

  function automatic int rr_winner(input logic [N-1:0] v, input int p);
    for (int k = 1; k <= N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return 0;
  endfunction

  always @(posedge clk) begin
    pipe1    <= alu_enable ? alu_f(alu_op1, alu_op2, alu_instruction) : 32'hBAADF00D;
    pipe3[0] <= alu_enable3 ? alu_f(alu_op1_3, alu_op2_3, alu_instr3) : 32'hDEADBEEF;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign alu_result  = pipe1;
  assign alu_result3 = pipe3[2];

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input alu_instruction_t ins);
    op1s[i] = a; op2s[i] = b; inss[i] = ins;
    req_op1[32*i +: 32] = a;
    req_op2[32*i +: 32] = b;
    req_instr[ALU_INSTR_W*i +: ALU_INSTR_W] = ins;
  endtask

  task automatic load_random(input int i);
    set_req(i, $urandom, $urandom, alu_instruction_t'(4'($urandom_range(8, 15))));
  endtask

  task automatic do_reset();
    reset = 1'b0; req_valid = '0; req_valid3 = '0; resp_ready = '0;
    #3;
    reset = 1'b1;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0; req_valid = '1; resp_ready = '1;
    #2;
    checks++; if (req_ready !== '0) $display("FAIL reset_req_ready: got %b want 0", req_ready); else passed++;
    checks++; if (resp_valid !== '0) $display("FAIL reset_resp_valid: got %b want 0", resp_valid); else passed++;
    checks++; if (resp_result !== 32'h0) $display("FAIL reset_resp_result: got %h want 0", resp_result); else passed++;
    checks++; if (alu_enable !== 1'b0 || alu_op1 !== 32'h0 || alu_op2 !== 32'h0)
      $display("FAIL reset_alu_outputs: got en=%b op1=%h op2=%h want 0", alu_enable, alu_op1, alu_op2); else passed++;
    checks++; if (alu_instruction !== ALU_ADD) $display("FAIL reset_alu_instr: got %0d want 0", alu_instruction); else passed++;
    step(); step(); #1;
    checks++; if (busy !== 1'b0 || alu_enable !== 1'b0) $display("FAIL reset_held_idle: got busy=%b en=%b want 0", busy, alu_enable); else passed++;
    req_valid = '0;
    reset = 1'b1;
    step();
  endtask

  task automatic test_single();
    do_reset();
    resp_ready = '1;
    set_req(2, 32'h3F800000, 32'h40000000, ALU_FADD);
    req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) $display("FAIL single_grant: got %b want 0100", req_ready); else passed++;
    step(); req_valid = '0; #1;
    checks++; if (alu_enable !== 1'b1 || alu_op1 !== 32'h3F800000 || alu_op2 !== 32'h40000000 || alu_instruction !== ALU_FADD)
      $display("FAIL single_issue: got en=%b op1=%h op2=%h ins=%0d", alu_enable, alu_op1, alu_op2, alu_instruction); else passed++;
    step(); #1;
    checks++; if (alu_enable !== 1'b0 || resp_valid !== '0) $display("FAIL single_wait: got en=%b rv=%b want 0", alu_enable, resp_valid); else passed++;
    step(); #1;
    checks++; if (resp_valid !== 4'b0100 || resp_result !== 32'h40400000)
      $display("FAIL single_resp: got rv=%b res=%h want 0100 40400000", resp_valid, resp_result); else passed++;
    step(); #1;
    checks++; if (busy !== 1'b0) $display("FAIL single_idle: got busy=%b want 0", busy); else passed++;
  endtask

  task automatic test_round_robin();
    int p, w, t, g_prev, ens;
    logic [N-1:0] oh;
    logic [31:0] er;
    do_reset();
    resp_ready = '1;
    for (int i = 0; i < N; i++) load_random(i);
    req_valid = '1;
    p = N - 1;
    g_prev = 0;
    for (int n = 0; n < 5; n++) begin
      #1;
      t = 0;
      while (req_ready == '0 && t < 8) begin step(); #1; t++; end
      w = rr_winner(req_valid, p);
      oh = '0; oh[w] = 1'b1;
      checks++; if (req_ready !== oh) $display("FAIL rr_grant[%0d]: got %b want %b", n, req_ready, oh); else passed++;
      if (n > 0) begin
        checks++; if (cyc - g_prev != 4) $display("FAIL rr_interval[%0d]: got %0d want 4", n, cyc - g_prev); else passed++;
      end
      g_prev = cyc;
      er = alu_f(op1s[w], op2s[w], inss[w]);
      ens = 0; t = 0;
      do begin step(); #1; t++; if (alu_enable) ens++; end while (resp_valid == '0 && t < 10);
      checks++; if (t != 3 || resp_valid !== oh || resp_result !== er || ens != 1)
        $display("FAIL rr_resp[%0d]: got lat=%0d rv=%b res=%h en=%0d want 3 %b %h 1", n, t, resp_valid, resp_result, ens, oh, er); else passed++;
      load_random(w);
      p = w;
      step();
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    set_req(1, 32'h40000000, 32'h40400000, ALU_FMUL);
    req_valid = 4'b0010;
    #1;
    checks++; if (req_ready !== 4'b0010) $display("FAIL bp_grant: got %b want 0010", req_ready); else passed++;
    step(); req_valid = 4'b1101;
    step(); step(); #1;
    for (int h = 0; h < 5; h++) begin
      checks++; if (resp_valid !== 4'b0010 || resp_result !== 32'h40C00000 || req_ready !== '0 || busy !== 1'b1)
        $display("FAIL bp_hold[%0d]: got rv=%b res=%h rr=%b busy=%b want 0010 40c00000 0000 1", h, resp_valid, resp_result, req_ready, busy); else passed++;
      if (h < 4) begin step(); #1; end
    end
    resp_ready = 4'b0010;
    step(); #1;
    checks++; if (busy !== 1'b0 || req_ready !== 4'b0100) $display("FAIL bp_release: got busy=%b rr=%b want 0 0100", busy, req_ready); else passed++;
    req_valid = '0;
    step(); #1;
    checks++; if (busy !== 1'b0) $display("FAIL bp_drop_valid: got busy=%b want 0", busy); else passed++;
  endtask

  task automatic test_wrong_ready();
    logic [31:0] er;
    do_reset();
    load_random(3);
    er = alu_f(op1s[3], op2s[3], inss[3]);
    req_valid = 4'b1000;
    #1;
    checks++; if (req_ready !== 4'b1000) $display("FAIL wr_grant: got %b want 1000", req_ready); else passed++;
    step(); req_valid = '0;
    step(); step(); #1;
    checks++; if (resp_valid !== 4'b1000 || resp_result !== er) $display("FAIL wr_resp: got rv=%b res=%h want 1000 %h", resp_valid, resp_result, er); else passed++;
    resp_ready = 4'b0111;
    for (int h = 0; h < 2; h++) begin
      step(); #1;
      checks++; if (resp_valid !== 4'b1000 || busy !== 1'b1 || resp_result !== er)
        $display("FAIL wr_ignored[%0d]: got rv=%b busy=%b res=%h want 1000 1 %h", h, resp_valid, busy, resp_result, er); else passed++;
    end
    resp_ready = 4'b1000;
    step(); #1;
    checks++; if (busy !== 1'b0 || resp_valid !== '0) $display("FAIL wr_accept: got busy=%b rv=%b want 0 0", busy, resp_valid); else passed++;
  endtask

  task automatic test_reset_mid();
    logic seen;
    do_reset();
    resp_ready = '1;
    load_random(1);
    req_valid = 4'b0010;
    step(); req_valid = '0;
    step();
    reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || alu_enable !== 1'b0 || alu_op1 !== 32'h0 || alu_op2 !== 32'h0 || resp_valid !== '0 || resp_result !== 32'h0)
      $display("FAIL midrst_async: got busy=%b en=%b op1=%h op2=%h rv=%b res=%h want 0", busy, alu_enable, alu_op1, alu_op2, resp_valid, resp_result); else passed++;
    step(); reset = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin step(); #1; if (resp_valid != '0) seen = 1'b1; end
    checks++; if (seen !== 1'b0) $display("FAIL midrst_no_resp: got %b want 0", seen); else passed++;
    req_valid = '1;
    #1;
    checks++; if (req_ready !== 4'b0001) $display("FAIL midrst_first_grant: got %b want 0001", req_ready); else passed++;
    req_valid = '0;
    step();
  endtask

  task automatic test_random();
    int p, w, t, hold;
    logic [N-1:0] v, oh;
    logic [31:0] er;
    do_reset();
    p = N - 1;
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < N; i++) load_random(i);
      v = N'($urandom_range(1, (1 << N) - 1));
      req_valid = v;
      resp_ready = N'($urandom);
      #1;
      w = rr_winner(v, p);
      oh = '0; oh[w] = 1'b1;
      checks++; if (busy !== 1'b0 || req_ready !== oh) $display("FAIL rnd_grant[%0d]: got busy=%b rr=%b want 0 %b", n, busy, req_ready, oh); else passed++;
      er = alu_f(op1s[w], op2s[w], inss[w]);
      t = 0;
      do begin
        step(); req_valid = N'($urandom); resp_ready = N'($urandom) & ~oh; #1; t++;
      end while (resp_valid == '0 && t < 10);
      checks++; if (t != 3 || resp_valid !== oh || resp_result !== er)
        $display("FAIL rnd_resp[%0d]: got lat=%0d rv=%b res=%h want 3 %b %h", n, t, resp_valid, resp_result, oh, er); else passed++;
      hold = $urandom_range(0, 3);
      for (int h = 0; h < hold; h++) begin
        step(); resp_ready = N'($urandom) & ~oh; req_valid = N'($urandom); #1;
        checks++; if (resp_valid !== oh || resp_result !== er)
          $display("FAIL rnd_hold[%0d]: got rv=%b res=%h want %b %h", n, resp_valid, resp_result, oh, er); else passed++;
      end
      resp_ready = oh | N'($urandom);
      step();
      p = w;
    end
    req_valid = '0;
    resp_ready = '0;
    step();
  endtask

  task automatic test_latency3();
    logic [N-1:0] en_seen, rv4, rv5;
    logic [31:0] res5;
    do_reset();
    resp_ready = '1;
    set_req(0, 32'h40000000, 32'h40400000, ALU_FADD);
    req_valid3 = 4'b0001;
    #1;
    checks++; if (req_ready3 !== 4'b0001) $display("FAIL lat3_grant: got %b want 0001", req_ready3); else passed++;
    en_seen = '0; rv4 = '0; rv5 = '0; res5 = '0;
    for (int c = 1; c <= 5; c++) begin
      step(); req_valid3 = '0; #1;
      if (alu_enable3) en_seen[c-1] = 1'b1;
      if (c == 4) rv4 = resp_valid3;
      if (c == 5) begin rv5 = resp_valid3; res5 = resp_result3; end
    end
    checks++; if (en_seen !== 4'b0001) $display("FAIL lat3_enable: got cycles %b want 0001", en_seen); else passed++;
    checks++; if (rv4 !== '0 || rv5 !== 4'b0001) $display("FAIL lat3_resp_cycle: got c4=%b c5=%b want 0000 0001", rv4, rv5); else passed++;
    checks++; if (res5 !== 32'h40A00000) $display("FAIL lat3_result: got %h want 40a00000", res5); else passed++;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clk = 1'b0; reset = 1'b1;
    req_valid = '0; req_valid3 = '0; resp_ready = '0;
    req_op1 = '0; req_op2 = '0; req_instr = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_wrong_ready();
    test_reset_mid();
    test_random();
    test_latency3();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
